ysyx_24100005_mem_arbiter: RTL and testbench
============================================

Name: ysyx_24100005_mem_arbiter

Overview:
- Shares the single DPI-backed data memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). This is the step from a single-cycle to a multi-cycle NPC.
- Arbitrates requests round-robin and sequences one outstanding memory transaction at a time.
- Routes the response, or a timeout error, back to the owning requester.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MASK_W, 8, write byte-mask width (matches npcmem_write wmask)
TIMEOUT, 16, max WAIT cycles before error response; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_req_addr  in  ADDR_W  IFU fetch address
ifu_resp_valid  out  1  one-cycle pulse, IFU response
ifu_resp_data  out  DATA_W  fetched word
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_req_addr  in  ADDR_W  LSU address
lsu_req_wen  in  1  1 = store, 0 = load
lsu_req_wdata  in  DATA_W  store data
lsu_req_wmask  in  MASK_W  store byte mask
lsu_resp_valid  out  1  one-cycle pulse, LSU response (load data or store ack)
lsu_resp_data  out  DATA_W  load data (0 for stores)
resp_err  out  1  qualifies whichever resp_valid is high; 1 = timeout
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  memory address
mem_wen  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_wmask  out  MASK_W  memory byte mask
mem_resp_valid  in  1  memory response/ack, one cycle
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, last_grant=IFU, timeout counter=0.
  - All registered outputs and latched request fields are 0.
  - An in-flight transaction is abandoned with no response pulse.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Grant selection: only one valid requester -> that requester. Both valid -> the one NOT equal to last_grant.
  - `*_req_ready` = (state==IDLE) && granted. It is combinational and at most one is high.
  - On handshake: latch addr, wen, wdata, wmask and owner; set last_grant=owner; go to REQ.
  - IFU requests latch wen=0, wmask=0, wdata=0.
- REQ:
  - mem_req_valid=1. mem_addr/wen/wdata/wmask are driven from the latched registers and held stable.
  - On mem_req_ready go to WAIT and clear the counter. Otherwise stay; no timeout applies in REQ.
- WAIT:
  - Counter increments each cycle.
  - mem_resp_valid=1: latch mem_rdata (0 if store), resp_err=0, go to RESP.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: data=0, resp_err=1, go to RESP.
  - Counter width is $clog2(TIMEOUT+1).
- RESP:
  - Exactly one cycle. Owner's resp_valid=1; the other resp_valid=0. resp_data carries the latched value; resp_err as set.
  - Next state is IDLE. Requesters must accept the pulse; there is no backpressure.
- resp_data outputs hold their last value between pulses and are meaningful only with resp_valid.
- mem_resp_valid outside WAIT (including the same cycle as mem_req_ready) is ignored.
- Minimum latency: accept at cycle T, REQ with ready at T+1, response at T+2, resp_valid at T+3. Next accept no earlier than T+4.
- Request inputs changing while not ready do not affect the transaction in flight.

Test Plan:
1. IFU-only fetch:
   - Stimulus: addr 0x80000000, mem_req_ready=1, mem_resp_valid one cycle later with rdata 0x00100073.
   - Required: ifu_resp_valid=1 with data 0x00100073 exactly 3 cycles after accept; resp_err=0; lsu_resp_valid=0 throughout.
2. Simultaneous requests from reset, both held valid:
   - LSU granted first, then IFU, then LSU (alternating).
   - Each grant has ready high for exactly one cycle, only in IDLE.
3. LSU store with delayed memory accept:
   - Stimulus: addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F; mem_req_ready delayed 3 cycles.
   - Required: mem fields stable for all 4 REQ cycles with mem_wen=1.
   - Required: after ack, lsu_resp_valid=1, lsu_resp_data=0.
4. Timeout (TIMEOUT=16):
   - Stimulus: mem never asserts resp_valid after accept.
   - Required: after 16 WAIT cycles, owner resp_valid=1, resp_err=1, data=0; FSM returns to IDLE and the next request proceeds normally.
5. Reset asserted mid-WAIT:
   - Required: outputs go 0 immediately (async).
   - Required: a mem_resp_valid arriving after release is ignored; no resp pulse.
6. Spurious mem_resp_valid in IDLE and in REQ:
   - Required: no state change, no resp pulse, and the eventual real response is still delivered correctly.

Source files
------------

// File: rtl/ysyx_24100005_mem_arbiter.sv
// ysyx_24100005_mem_arbiter
// Shares the single data memory port between the IFU and the LSU. Requests
// are granted round-robin, one memory transaction is outstanding at a time,
// and the response (or a timeout error) is routed back to the owner.

module ysyx_24100005_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MASK_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_resp_data,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [MASK_W-1:0] lsu_req_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_resp_data,

    output logic              resp_err,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    // A zero TIMEOUT disables the watchdog; keep the counter at least 1 bit wide
    localparam int              CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int              CNT_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_LAST_I[CNT_W-1:0];
    localparam logic            TMO_EN     = (TIMEOUT != 0);

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              last_grant;
    logic              owner;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] ifu_data_q;
    logic [DATA_W-1:0] lsu_data_q;
    logic              err_q;

    logic grant_ifu;
    logic grant_lsu;
    logic accept;
    logic resp_ok;
    logic resp_tmo;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_grant == OWN_IFU));
        grant_ifu = ifu_req_valid && !grant_lsu;
    end

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the handshake and response strobes
    always_comb begin
        next_state     = state;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        accept         = 1'b0;
        resp_ok        = 1'b0;
        resp_tmo       = 1'b0;
        case (state)
            S_IDLE: begin
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
                if (grant_ifu || grant_lsu) begin
                    accept     = 1'b1;
                    next_state = S_REQ;
                end
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    resp_ok    = 1'b1;
                    next_state = S_RESP;
                end else if (TMO_EN && (cnt == CNT_LAST)) begin
                    resp_tmo   = 1'b1;
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                ifu_resp_valid = (owner == OWN_IFU);
                lsu_resp_valid = (owner == OWN_LSU);
                next_state     = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Capture the granted request so later input changes cannot disturb it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= OWN_IFU;
            owner      <= OWN_IFU;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else if (accept) begin
            last_grant <= grant_lsu;
            owner      <= grant_lsu;
            if (grant_lsu) begin
                addr_q  <= lsu_req_addr;
                wen_q   <= lsu_req_wen;
                wdata_q <= lsu_req_wdata;
                wmask_q <= lsu_req_wmask;
            end else begin
                addr_q  <= ifu_req_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
        end
    end

    // Wait-cycle counter, restarted when memory accepts the request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if ((state == S_REQ) && mem_req_ready) begin
            cnt <= '0;
        end else if (state == S_WAIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Response data per requester, held between pulses; stores and timeouts return zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifu_data_q <= '0;
            lsu_data_q <= '0;
            err_q      <= 1'b0;
        end else if (resp_ok || resp_tmo) begin
            err_q <= resp_tmo;
            if (owner == OWN_LSU) begin
                lsu_data_q <= (resp_tmo || wen_q) ? '0 : mem_rdata;
            end else begin
                ifu_data_q <= resp_tmo ? '0 : mem_rdata;
            end
        end
    end

    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;
    assign ifu_resp_data = ifu_data_q;
    assign lsu_resp_data = lsu_data_q;
    assign resp_err      = err_q;

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Bench for ysyx_24100005_mem_arbiter: per-scenario tasks plus a response
// scoreboard fed by the tasks and drained by a negedge monitor.

module tb_ysyx_24100005_mem_arbiter;

    localparam logic [31:0] KEY = 32'h5A5A_0000;

    typedef struct packed {
        logic        lsu;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_resp_data;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [7:0]  lsu_req_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_data;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    logic        man_ready;
    logic        man_resp;
    logic [31:0] man_rdata;
    logic        auto_en;
    logic        auto_resp;
    logic [31:0] auto_rdata;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    ysyx_24100005_mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_data  (ifu_resp_data),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_wmask  (lsu_req_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_data  (lsu_resp_data),
        .resp_err       (resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory side: either a scripted driver or an auto responder answering one cycle after accept
    assign mem_req_ready  = auto_en ? 1'b1 : man_ready;
    assign mem_resp_valid = auto_en ? auto_resp : man_resp;
    assign mem_rdata      = auto_en ? auto_rdata : man_rdata;

    // Auto responder: loads return address xor KEY
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_resp  <= 1'b0;
            auto_rdata <= 32'h0;
        end else begin
            auto_resp <= 1'b0;
            if (auto_en && mem_req_valid && mem_req_ready) begin
                auto_resp  <= 1'b1;
                auto_rdata <= mem_addr ^ KEY;
            end
        end
    end

    // Scoreboard monitor: every response pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && (ifu_req_ready && lsu_req_ready)) begin
            checks++;
            errors++;
            $display("[TB] FAIL both_ready got ifu=1 lsu=1 want at most one");
        end
        if (!rst && (ifu_resp_valid || lsu_resp_valid)) begin
            exp_t e;
            checks++;
            if (ifu_resp_valid && lsu_resp_valid) begin
                errors++;
                $display("[TB] FAIL resp_both got ifu=1 lsu=1 want one");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL resp_unexpected got ifu=%0b lsu=%0b want no pulse", ifu_resp_valid, lsu_resp_valid);
            end else begin
                e = exp_q.pop_front();
                if (lsu_resp_valid !== e.lsu
                    || (e.lsu ? lsu_resp_data : ifu_resp_data) !== e.data
                    || resp_err !== e.err) begin
                    errors++;
                    $display("[TB] FAIL resp_scoreboard got lsu=%0b data=%h err=%0b want lsu=%0b data=%h err=%0b",
                             lsu_resp_valid, (lsu_resp_valid ? lsu_resp_data : ifu_resp_data), resp_err,
                             e.lsu, e.data, e.err);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, resp_err, ifu_req_ready, lsu_req_ready} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want 000000",
                     {mem_req_valid, ifu_resp_valid, lsu_resp_valid, resp_err, ifu_req_ready, lsu_req_ready});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_wmask, mem_wen, ifu_resp_data, lsu_resp_data} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data got addr=%h wdata=%h wmask=%h wen=%b idata=%h ldata=%h want all 0",
                     mem_addr, mem_wdata, mem_wmask, mem_wen, ifu_resp_data, lsu_resp_data);
        end
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_ifu_fetch();
        exp_q.push_back('{lsu: 1'b0, data: 32'h0010_0073, err: 1'b0});
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0000;
        man_ready     = 1'b1;
        @(negedge clk);
        checks++;
        if (ifu_req_ready !== 1'b1 || lsu_req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ifu_accept got ifu_ready=%b lsu_ready=%b want 1 0", ifu_req_ready, lsu_req_ready);
        end
        next_cycle();
        ifu_req_valid = 1'b0;
        ifu_req_addr  = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ifu_memreq got valid=%b addr=%h wen=%b want 1 80000000 0", mem_req_valid, mem_addr, mem_wen);
        end
        next_cycle();
        man_ready = 1'b0;
        man_resp  = 1'b1;
        man_rdata = 32'h0010_0073;
        @(negedge clk);
        checks++;
        if (ifu_resp_valid !== 1'b0 || lsu_resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ifu_early got ifu=%b lsu=%b want 0 0", ifu_resp_valid, lsu_resp_valid);
        end
        next_cycle();
        man_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (ifu_resp_valid !== 1'b1 || ifu_resp_data !== 32'h0010_0073 || resp_err !== 1'b0 || lsu_resp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ifu_resp got v=%b d=%h err=%b lsu=%b want 1 00100073 0 0",
                     ifu_resp_valid, ifu_resp_data, resp_err, lsu_resp_valid);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic exp_lsu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int   g = 0;
        exp_q.push_back('{lsu: 1'b1, data: 32'h8000_4000 ^ KEY, err: 1'b0});
        exp_q.push_back('{lsu: 1'b0, data: 32'h8000_0100 ^ KEY, err: 1'b0});
        exp_q.push_back('{lsu: 1'b1, data: 32'h8000_4000 ^ KEY, err: 1'b0});
        exp_q.push_back('{lsu: 1'b0, data: 32'h8000_0100 ^ KEY, err: 1'b0});
        auto_en       = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0100;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_4000;
        lsu_req_wen   = 1'b0;
        lsu_req_wdata = 32'hFFFF_FFFF;
        lsu_req_wmask = 8'hFF;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (ifu_req_ready || lsu_req_ready) begin
                checks++;
                if (g >= 4 || c != 4 * g || lsu_req_ready !== exp_lsu[g]) begin
                    errors++;
                    $display("[TB] FAIL rr_grant got cycle=%0d lsu=%b want cycle=%0d lsu=%b",
                             c, lsu_req_ready, 4 * g, (g < 4) ? exp_lsu[g] : 1'b0);
                end
                g++;
            end
            next_cycle();
            if (c == 12) begin
                ifu_req_valid = 1'b0;
                lsu_req_valid = 1'b0;
            end
        end
        repeat (4) next_cycle();
        auto_en = 1'b0;
        checks++;
        if (g != 4 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rr_count got grants=%0d pending=%0d want 4 0", g, exp_q.size());
        end
    endtask

    task automatic test_store_delayed();
        exp_q.push_back('{lsu: 1'b1, data: 32'h0, err: 1'b0});
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_1000;
        lsu_req_wen   = 1'b1;
        lsu_req_wdata = 32'hDEAD_BEEF;
        lsu_req_wmask = 8'h0F;
        man_ready     = 1'b0;
        @(negedge clk);
        checks++;
        if (lsu_req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL st_accept got %b want 1", lsu_req_ready);
        end
        next_cycle();
        lsu_req_valid = 1'b0;
        lsu_req_addr  = 32'h0BAD_0BAD;
        lsu_req_wdata = 32'h0;
        lsu_req_wmask = 8'hF0;
        for (int k = 0; k < 4; k++) begin
            man_ready = (k == 3);
            @(negedge clk);
            checks++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_1000 || mem_wen !== 1'b1
                || mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 8'h0F) begin
                errors++;
                $display("[TB] FAIL st_req%0d got v=%b a=%h wen=%b d=%h m=%h want 1 80001000 1 deadbeef 0f",
                         k, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
            end
            next_cycle();
        end
        man_ready = 1'b0;
        man_resp  = 1'b1;
        man_rdata = 32'h1234_5678;
        next_cycle();
        man_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 32'h0 || resp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL st_resp got v=%b d=%h err=%b want 1 0 0", lsu_resp_valid, lsu_resp_data, resp_err);
        end
        next_cycle();
        lsu_req_wen = 1'b0;
    endtask

    task automatic test_timeout();
        int early = 0;
        int seen  = 0;
        exp_q.push_back('{lsu: 1'b0, data: 32'h0, err: 1'b1});
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0040;
        man_ready     = 1'b1;
        man_resp      = 1'b0;
        @(negedge clk);
        checks++;
        if (ifu_req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tmo_accept got %b want 1", ifu_req_ready);
        end
        next_cycle();
        ifu_req_valid = 1'b0;
        for (int c = 1; c < 18; c++) begin
            @(negedge clk);
            if (ifu_resp_valid || lsu_resp_valid) early++;
            next_cycle();
            if (c == 1) man_ready = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (early != 0 || ifu_resp_valid !== 1'b1 || resp_err !== 1'b1 || ifu_resp_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL tmo_resp got early=%0d v=%b err=%b d=%h want 0 1 1 0",
                     early, ifu_resp_valid, resp_err, ifu_resp_data);
        end
        next_cycle();
        exp_q.push_back('{lsu: 1'b1, data: 32'h8000_0080 ^ KEY, err: 1'b0});
        auto_en       = 1'b1;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_0080;
        @(negedge clk);
        checks++;
        if (lsu_req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tmo_next_accept got %b want 1", lsu_req_ready);
        end
        next_cycle();
        lsu_req_valid = 1'b0;
        for (int c = 0; c < 8 && seen == 0; c++) begin
            @(negedge clk);
            if (lsu_resp_valid) seen = 1;
            next_cycle();
        end
        checks++;
        if (seen != 1 || resp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tmo_next_resp got seen=%0d err=%b want 1 0", seen, resp_err);
        end
        auto_en = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        int pulses = 0;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_2000;
        man_ready     = 1'b1;
        next_cycle();
        lsu_req_valid = 1'b0;
        next_cycle();
        man_ready = 1'b0;
        next_cycle();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid, resp_err} !== 4'b0
            || {mem_addr, mem_wen, ifu_resp_data, lsu_resp_data} !== '0) begin
            errors++;
            $display("[TB] FAIL rst_async got mv=%b a=%h wen=%b err=%b ld=%h want all 0",
                     mem_req_valid, mem_addr, mem_wen, resp_err, lsu_resp_data);
        end
        next_cycle();
        rst = 1'b0;
        man_resp  = 1'b1;
        man_rdata = 32'h1111_2222;
        next_cycle();
        man_resp = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ifu_resp_valid || lsu_resp_valid || mem_req_valid) pulses++;
            next_cycle();
        end
        checks++;
        if (pulses != 0 || lsu_resp_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_ignore got activity=%0d ld=%h want 0 0", pulses, lsu_resp_data);
        end
    endtask

    task automatic test_spurious();
        int pulses = 0;
        man_ready = 1'b0;
        man_resp  = 1'b1;
        man_rdata = 32'hBAD0_BAD0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (ifu_resp_valid || lsu_resp_valid || mem_req_valid) pulses++;
            next_cycle();
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("[TB] FAIL spur_idle got activity=%0d want 0", pulses);
        end
        exp_q.push_back('{lsu: 1'b1, data: 32'hCAFE_F00D, err: 1'b0});
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_3000;
        lsu_req_wen   = 1'b0;
        @(negedge clk);
        checks++;
        if (lsu_req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL spur_accept got %b want 1", lsu_req_ready);
        end
        next_cycle();
        lsu_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL spur_req got %b want 1", mem_req_valid);
        end
        next_cycle();
        man_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL spur_req_ready got %b want 1", mem_req_valid);
        end
        next_cycle();
        man_ready = 1'b0;
        man_resp  = 1'b0;
        @(negedge clk);
        checks++;
        if (lsu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spur_wait got resp=%b mv=%b want 0 0", lsu_resp_valid, mem_req_valid);
        end
        next_cycle();
        man_resp  = 1'b1;
        man_rdata = 32'hCAFE_F00D;
        next_cycle();
        man_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (lsu_resp_valid !== 1'b1 || lsu_resp_data !== 32'hCAFE_F00D || resp_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL spur_resp got v=%b d=%h err=%b want 1 cafef00d 0", lsu_resp_valid, lsu_resp_data, resp_err);
        end
        next_cycle();
    endtask

    // Watchdog so a stuck design still ends the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        ifu_req_valid = 1'b0;
        ifu_req_addr  = 32'h0;
        lsu_req_valid = 1'b0;
        lsu_req_addr  = 32'h0;
        lsu_req_wen   = 1'b0;
        lsu_req_wdata = 32'h0;
        lsu_req_wmask = 8'h0;
        man_ready     = 1'b0;
        man_resp      = 1'b0;
        man_rdata     = 32'h0;
        auto_en       = 1'b0;

        test_reset();
        test_round_robin();
        test_ifu_fetch();
        test_store_delayed();
        test_timeout();
        test_reset_mid_wait();
        test_spurious();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL pending_responses got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
